// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage hazard bus between the ID/EX control path and fwd_hazard_ctrl.
// Optional WB_BYPASS_EN macro adds the ID-stage writeback bypass flags.
interface fwd_hazard_ctrl_if #(
   parameter int REG_AW      = 5,
   parameter int STALL_CNT_W = 16
);
   logic                   id_valid;
   logic [REG_AW-1:0]      id_rs1;
   logic [REG_AW-1:0]      id_rs2;
   logic [REG_AW-1:0]      id_rd;
   logic                   id_regwrite;
   logic                   id_memread;
   logic                   flush;
   logic [1:0]             ForwardA;
   logic [1:0]             ForwardB;
   logic                   stall;
   logic                   ex_bubble;
   logic [STALL_CNT_W-1:0] stall_cnt;
`ifdef WB_BYPASS_EN
   logic                   id_bypass_a;
   logic                   id_bypass_b;
`endif

   modport master (
`ifdef WB_BYPASS_EN
      input  id_bypass_a, id_bypass_b,
`endif
      output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, flush,
      input  ForwardA, ForwardB, stall, ex_bubble, stall_cnt
   );

   modport slave (
`ifdef WB_BYPASS_EN
      output id_bypass_a, id_bypass_b,
`endif
      input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, flush,
      output ForwardA, ForwardB, stall, ex_bubble, stall_cnt
   );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX operand forwarding selects and load-use stall control for a 5-stage pipeline,
// using shadow EX/MEM/WB destination records. Optional macro: WB_BYPASS_EN.
module fwd_hazard_ctrl #(
   parameter int REG_AW      = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   fwd_hazard_ctrl_if.slave bus
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } ex_rec_t;

   // Past EX only the destination side is ever consulted.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
   } dst_rec_t;

   localparam logic [REG_AW-1:0]      REG_ZERO = {REG_AW{1'b0}};
   localparam logic [STALL_CNT_W-1:0] CNT_MAX  = {STALL_CNT_W{1'b1}};

   ex_rec_t                ex_q, ex_d;
   dst_rec_t               mem_q, mem_d;
   dst_rec_t               wb_q, wb_d;
   logic                   ex_bubble_q, ex_bubble_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   load_use_s;
   logic                   stall_s;
   logic [1:0]             fwd_a_s;
   logic [1:0]             fwd_b_s;

   function automatic logic dst_hit(input dst_rec_t rec, input logic [REG_AW-1:0] src);
      return rec.valid & rec.regwrite & (rec.rd != REG_ZERO) & (rec.rd == src);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic ex_valid, input dst_rec_t mem,
                                          input dst_rec_t wb, input logic [REG_AW-1:0] src);
      logic [1:0] sel;
      sel = 2'b00;
      if (!ex_valid) begin
         sel = 2'b00;
      end else if (dst_hit(mem, src)) begin
         sel = 2'b10;
      end else if (dst_hit(wb, src)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Load-use detection; a redirect discards the consumer, so flush masks it.
   always_comb begin
      load_use_s = bus.id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != REG_ZERO) &
                   ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));
      stall_s    = load_use_s & ~bus.flush;
      fwd_a_s    = fwd_sel(ex_q.valid, mem_q, wb_q, ex_q.rs1);
      fwd_b_s    = fwd_sel(ex_q.valid, mem_q, wb_q, ex_q.rs2);
   end

   // Next-state for the shadow records, bubble flag and stall counter.
   always_comb begin
      ex_d        = '0;
      mem_d       = '0;
      wb_d        = '0;
      ex_bubble_d = 1'b0;
      stall_cnt_d = stall_cnt_q;

      if (stall_s | bus.flush) begin
         ex_d = '0;
      end else begin
         ex_d.valid    = bus.id_valid;
         ex_d.rs1      = bus.id_rs1;
         ex_d.rs2      = bus.id_rs2;
         ex_d.rd       = bus.id_rd;
         ex_d.regwrite = bus.id_regwrite & bus.id_valid;
         ex_d.memread  = bus.id_memread & bus.id_valid;
      end

      mem_d.valid    = ex_q.valid;
      mem_d.rd       = ex_q.rd;
      mem_d.regwrite = ex_q.regwrite;
      wb_d           = mem_q;
      ex_bubble_d    = stall_s | bus.flush;

      if (stall_s && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Pipeline shadow registers; reset clears every record so nothing stalls or forwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         ex_bubble_q <= 1'b0;
         stall_cnt_q <= {STALL_CNT_W{1'b0}};
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         ex_bubble_q <= ex_bubble_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.ForwardA  = fwd_a_s;
   assign bus.ForwardB  = fwd_b_s;
   assign bus.stall     = stall_s;
   assign bus.ex_bubble = ex_bubble_q;
   assign bus.stall_cnt = stall_cnt_q;

`ifdef WB_BYPASS_EN
   assign bus.id_bypass_a = dst_hit(wb_q, bus.id_rs1);
   assign bus.id_bypass_b = dst_hit(wb_q, bus.id_rs2);
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl with a cycle-tagged scoreboard queue.
module tb_fwd_hazard_ctrl;

   localparam int REG_AW      = 5;
   localparam int STALL_CNT_W = 16;

   typedef struct {
      int    cyc;
      string nm;
      logic [1:0]             fa;
      logic [1:0]             fb;
      logic                   st;
      logic                   bb;
      logic [STALL_CNT_W-1:0] cnt;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;
   exp_t sb[$];

   fwd_hazard_ctrl_if #(.REG_AW(REG_AW), .STALL_CNT_W(STALL_CNT_W)) bus ();

   fwd_hazard_ctrl #(.REG_AW(REG_AW), .STALL_CNT_W(STALL_CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare whenever an expectation is tagged for the current cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         checks++;
         if ({bus.ForwardA, bus.ForwardB, bus.stall, bus.ex_bubble, bus.stall_cnt} !==
             {e.fa, e.fb, e.st, e.bb, e.cnt}) begin
            errors++;
            $display("FAIL %s: got fa=%b fb=%b stall=%b bubble=%b cnt=%0d, want fa=%b fb=%b stall=%b bubble=%b cnt=%0d",
                     e.nm, bus.ForwardA, bus.ForwardB, bus.stall, bus.ex_bubble, bus.stall_cnt,
                     e.fa, e.fb, e.st, e.bb, e.cnt);
         end
      end
   end

   task automatic step(input int r, input int v, input int s1, input int s2, input int d,
                       input int rw, input int mr, input int fl, input int chk,
                       input int fa, input int fb, input int st, input int bb, input int cnt,
                       input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst             = r[0];
      bus.id_valid    = v[0];
      bus.id_rs1      = REG_AW'(s1);
      bus.id_rs2      = REG_AW'(s2);
      bus.id_rd       = REG_AW'(d);
      bus.id_regwrite = rw[0];
      bus.id_memread  = mr[0];
      bus.flush       = fl[0];
      if (chk != 0) begin
         e.cyc = cyc;
         e.nm  = nm;
         e.fa  = 2'(fa);
         e.fb  = 2'(fb);
         e.st  = st[0];
         e.bb  = bb[0];
         e.cnt = STALL_CNT_W'(cnt);
         sb.push_back(e);
      end
   endtask

   task automatic nop(input int chk, input int fa, input int fb, input int st, input int bb,
                      input int cnt, input string nm);
      step(0, 0, 0, 0, 0, 0, 0, 0, chk, fa, fb, st, bb, cnt, nm);
   endtask

   initial begin
      cyc = 0; checks = 0; errors = 0;
      rst = 1'b1;
      bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
      bus.id_regwrite = 1'b0; bus.id_memread = 1'b0; bus.flush = 1'b0;
      repeat (2) @(posedge clk);

      //   r v rs1 rs2 rd rw mr fl chk fa fb st bb cnt
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "reset_state");
      // add x5; sub x6,x5,x7 back-to-back
      step(0, 1, 1, 2, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0, "add_issue");
      step(0, 1, 5, 7, 6, 1, 0, 0, 1, 0, 0, 0, 0, 0, "sub_in_id");
      nop(1, 2, 0, 0, 0, 0, "exmem_fwd_a");
      nop(1, 0, 0, 0, 0, 0, "ex_nop_idle");
      // add x5; nop; or x8,x9,x5
      step(0, 1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, "");
      nop(0, 0, 0, 0, 0, 0, "");
      step(0, 1, 9, 5, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, "");
      nop(1, 0, 1, 0, 0, 0, "memwb_fwd_b");
      // add x5; add x5; sub x6,x5,x5
      step(0, 1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, "");
      step(0, 1, 3, 4, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, "");
      step(0, 1, 5, 5, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, "");
      nop(1, 2, 2, 0, 0, 0, "exmem_priority");
      nop(1, 0, 0, 0, 0, 0, "ex_invalid");
      // lw x5; add x6,x5,x1 (ID held while stalled)
      step(0, 1, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, "");
      step(0, 1, 5, 1, 6, 1, 0, 0, 1, 0, 0, 1, 0, 0, "load_use_stall");
      step(0, 1, 5, 1, 6, 1, 0, 0, 1, 0, 0, 0, 1, 1, "bubble_after_stall");
      nop(1, 1, 0, 0, 0, 1, "load_fwd_wb");
      // add x0; sub x6,x0,x0; lw x0; add x6,x0,x0
      step(0, 1, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "");
      step(0, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, "");
      nop(1, 0, 0, 0, 0, 1, "x0_no_fwd");
      step(0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "");
      step(0, 1, 0, 0, 6, 1, 0, 0, 1, 0, 0, 0, 0, 1, "lw_x0_no_stall");
      nop(1, 0, 0, 0, 0, 1, "lw_x0_no_fwd");
      nop(0, 0, 0, 0, 0, 0, "");
      // lw x7; add x8,x7,x7 with flush in the same cycle
      step(0, 1, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, "");
      step(0, 1, 7, 7, 8, 1, 0, 1, 1, 0, 0, 0, 0, 1, "flush_beats_stall");
      nop(1, 0, 0, 0, 1, 1, "flush_bubble");
      nop(0, 0, 0, 0, 0, 0, "");
      // lw x9; add x10,x2,x9 (hazard on rs2)
      step(0, 1, 1, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, "");
      step(0, 1, 2, 9, 10, 1, 0, 0, 1, 0, 0, 1, 0, 1, "load_use_rs2");
      step(0, 1, 2, 9, 10, 1, 0, 0, 1, 0, 0, 0, 1, 2, "stall_cnt_two");
      nop(1, 0, 1, 0, 0, 2, "load_fwd_wb_b");
      // lw x5; add x6,x5,x3 then reset while the stall is pending
      step(0, 1, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, "");
      step(0, 1, 5, 3, 6, 1, 0, 0, 1, 0, 0, 1, 0, 2, "stall_before_rst");
      step(1, 1, 5, 3, 6, 1, 0, 0, 1, 0, 0, 0, 0, 0, "rst_mid_stall");
      nop(1, 0, 0, 0, 0, 0, "post_rst_clean");
      step(0, 1, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, "");
      step(0, 1, 5, 7, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, "");
      nop(1, 2, 0, 0, 0, 0, "fwd_after_rst");

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations never compared, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
